result_queue_reader: RTL and testbench

Drains the detection result queue from its read side and converts each 32-bit word back into an (x, y, scale) detection record for the host-facing output stream. It sits between the result queue FIFO and the host/readback logic, consuming what the result store writes. It recognises the all-ones exit sentinel as end-of-frame, flags it on the stream, and keeps a count of drained detections.

---
 rtl/result_queue_reader_pkg.sv | 52 +++++
 rtl/result_queue_reader.sv | 125 ++++++++++++
 tb/tb_result_queue_reader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_queue_reader_pkg.sv
// Shared types, constants and the result-word decoder for the result queue reader.
package result_queue_reader_pkg;

  localparam int unsigned WORD_BITS          = 32;
  localparam int unsigned DEF_XBITS          = 12;
  localparam int unsigned DEF_YBITS          = 12;
  localparam int unsigned DEF_SCALE_BITS     = 8;
  localparam int unsigned DEF_COUNT_WIDTH    = 16;

  localparam logic [WORD_BITS-1:0] SENTINEL  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EMIT,
    S_EMIT_LAST,
    S_DONE
  } states_t;

  // Read side of the result queue, mirroring the write-side structs.
  typedef struct packed {
    logic rd_en;
  } rq_read_in_t;

  typedef struct packed {
    logic [WORD_BITS-1:0] data;
    logic                 empty;
  } rq_read_out_t;

  typedef struct packed {
    logic [WORD_BITS-1:0] x;
    logic [WORD_BITS-1:0] y;
    logic [WORD_BITS-1:0] scale;
  } det_rec_t;

  // Splits a packed word {x, y, scale}; x takes whatever sits above y and scale.
  function automatic det_rec_t decode_result(input logic [WORD_BITS-1:0] word,
                                             input int unsigned ybits,
                                             input int unsigned sbits);
    det_rec_t             rec;
    logic [WORD_BITS-1:0] ymask;
    logic [WORD_BITS-1:0] smask;
    ymask     = (32'd1 << ybits) - 32'd1;
    smask     = (32'd1 << sbits) - 32'd1;
    rec.x     = word >> (ybits + sbits);
    rec.y     = (word >> sbits) & ymask;
    rec.scale = word & smask;
    return rec;
  endfunction

endpackage

// File: rtl/result_queue_reader.sv
// Drains the detection result queue and streams decoded (x, y, scale) records,
// flagging the all-ones sentinel as end-of-frame and counting detections.
module result_queue_reader
  import result_queue_reader_pkg::*;
#(
  parameter int unsigned XBITS       = DEF_XBITS,
  parameter int unsigned YBITS       = DEF_YBITS,
  parameter int unsigned SCALE_BITS  = DEF_SCALE_BITS,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] det_count,
  output logic                   rq_rd_en,
  input  logic [31:0]            rq_data,
  input  logic                   rq_empty,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XBITS-1:0]       out_x,
  output logic [YBITS-1:0]       out_y,
  output logic [SCALE_BITS-1:0]  out_scale,
  output logic                   out_last
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  states_t                 state_q, state_n;
  logic                    busy_n, done_n, out_valid_n, out_last_n;
  logic [COUNT_WIDTH-1:0]  det_count_n;
  logic [XBITS-1:0]        out_x_n;
  logic [YBITS-1:0]        out_y_n;
  logic [SCALE_BITS-1:0]   out_scale_n;
  rq_read_out_t            rq;
  det_rec_t                rec;

  assign rq  = '{data: rq_data, empty: rq_empty};
  assign rec = decode_result(rq.data, YBITS, SCALE_BITS);

  // Next-state, read strobe and next values of the registered outputs.
  always_comb begin
    state_n     = state_q;
    det_count_n = det_count;
    out_x_n     = out_x;
    out_y_n     = out_y;
    out_scale_n = out_scale;
    rq_rd_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          det_count_n = '0;
          state_n     = S_FETCH;
        end
      end
      S_FETCH: begin
        // A read during reset would pop a word the next run never sees.
        if (!rq.empty && !reset) begin
          rq_rd_en = 1'b1;
          state_n  = S_LATCH;
        end
      end
      S_LATCH: begin
        if (rq.data == SENTINEL) begin
          out_x_n     = '0;
          out_y_n     = '0;
          out_scale_n = '0;
          state_n     = S_EMIT_LAST;
        end else begin
          out_x_n     = XBITS'(rec.x);
          out_y_n     = YBITS'(rec.y);
          out_scale_n = SCALE_BITS'(rec.scale);
          state_n     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (det_count != COUNT_MAX) det_count_n = det_count + COUNT_WIDTH'(1);
          state_n = S_FETCH;
        end
      end
      S_EMIT_LAST: begin
        if (out_ready) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
    out_valid_n = (state_n == S_EMIT) || (state_n == S_EMIT_LAST);
    out_last_n  = (state_n == S_EMIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      det_count <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_scale <= '0;
    end else begin
      state_q   <= state_n;
      busy      <= busy_n;
      done      <= done_n;
      det_count <= det_count_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      out_x     <= out_x_n;
      out_y     <= out_y_n;
      out_scale <= out_scale_n;
    end
  end

endmodule

// File: tb/tb_result_queue_reader.sv
// Randomized self-checking bench for result_queue_reader against a queue/record model.
module tb_result_queue_reader;

  localparam int unsigned XB   = 12;
  localparam int unsigned YB   = 12;
  localparam int unsigned SB   = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, busy, done, rq_rd_en, rq_empty;
  logic [CW-1:0] det_count;
  logic [31:0]   rq_data;
  logic          out_valid, out_ready, out_last;
  logic [XB-1:0] out_x;
  logic [YB-1:0] out_y;
  logic [SB-1:0] out_scale;

  always #5 clk = ~clk;

  result_queue_reader #(.XBITS(XB), .YBITS(YB), .SCALE_BITS(SB), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .det_count(det_count), .rq_rd_en(rq_rd_en), .rq_data(rq_data), .rq_empty(rq_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_scale(out_scale), .out_last(out_last)
  );

  // Queue model: the stimulus side advances push_cnt, the read port advances pop_cnt.
  logic [31:0]  mem [0:1023];
  int unsigned  push_cnt = 0;
  int unsigned  pop_cnt  = 0;
  logic         force_empty = 1'b0;

  assign rq_empty = force_empty || (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (rq_rd_en) begin
      rq_data <= mem[pop_cnt[9:0]];
      pop_cnt <= pop_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int unsigned e_x [0:63];
  int unsigned e_y [0:63];
  int unsigned e_s [0:63];
  int          n_exp;

  task automatic push_word(input logic [31:0] w);
    mem[push_cnt[9:0]] = w;
    push_cnt = push_cnt + 1;
  endtask

  task automatic gen_random(input int n);
    n_exp = n;
    for (int i = 0; i < n; i++) begin
      e_x[i] = $urandom_range(0, 4094);
      e_y[i] = $urandom_range(0, 4095);
      e_s[i] = $urandom_range(0, 255);
    end
  endtask

  task automatic load_frame();
    for (int i = 0; i < n_exp; i++)
      push_word(32'(e_x[i] * 1048576 + e_y[i] * 256 + e_s[i]));
    push_word(32'hFFFF_FFFF);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("rd_en_first_cycle", {31'd0, rq_rd_en}, {31'd0, !rq_empty});
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // mode 0: ready high; 1: random ready and empty stalls; 2: first beat held off 10 cycles.
  task automatic drain(input int mode, input int mid_start_after);
    int          idx = 0;
    int          cyc = 0;
    int          hold = 0;
    bit          fin = 0;
    bit          sent_last = 0;
    bit          stalled = 0;
    bit          mid_done = 0;
    logic [31:0] prev_fields = '0;
    while (!fin && cyc < 3000) begin
      case (mode)
        1: begin
          out_ready   = ($urandom_range(0, 3) != 0);
          force_empty = ($urandom_range(0, 3) == 0);
        end
        2: begin
          if (out_valid && hold < 10) begin
            out_ready = 1'b0;
            hold++;
          end else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
      if (!mid_done && mid_start_after >= 0 && idx >= mid_start_after && busy) begin
        start    = 1'b1;
        mid_done = 1;
      end else start = 1'b0;

      if (stalled) begin
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_fields_held", {out_x, out_y, out_scale}, prev_fields);
      end
      if (out_valid && !out_ready)
        check("no_rd_en_in_stall", {31'd0, rq_rd_en}, 32'd0);
      if (out_valid && out_ready) begin
        if (out_last) begin
          check("last_beat_index", 32'(idx), 32'(n_exp));
          check("last_fields_zero", {out_x, out_y, out_scale}, 32'd0);
          sent_last = 1;
        end else if (idx < n_exp) begin
          check("det_count_running", {28'd0, det_count}, sat(32'(idx)));
          check("rec_x", {20'd0, out_x}, e_x[idx]);
          check("rec_y", {20'd0, out_y}, e_y[idx]);
          check("rec_scale", {24'd0, out_scale}, e_s[idx]);
          idx++;
        end else begin
          check("extra_record", 32'(idx), 32'(n_exp));
        end
      end
      if (done) begin
        check("done_after_last", {31'd0, sent_last}, 32'd1);
        check("busy_during_done", {31'd0, busy}, 32'd1);
        fin = 1;
      end
      stalled     = out_valid && !out_ready;
      prev_fields = {out_x, out_y, out_scale};
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check("drain_timeout", 32'd0, 32'd1);
    start       = 1'b0;
    force_empty = 1'b0;
    out_ready   = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("det_count_final", {28'd0, det_count}, sat(32'(n_exp)));
  endtask

  task automatic run_frame(input int mode, input int mid_start_after);
    int unsigned p0;
    load_frame();
    p0 = pop_cnt;
    pulse_start();
    drain(mode, mid_start_after);
    check("reads_per_frame", pop_cnt - p0, 32'(n_exp + 1));
  endtask

  task automatic wait_for(input bit want_valid, input string tag);
    int c = 0;
    while (((want_valid && !out_valid) || (!want_valid && det_count == '0)) && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    push_word(32'h0050_0702);
    push_word(32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_outputs", {busy, done, out_valid, out_last, rq_rd_en}, 32'd0);
      check("rst_fields", {out_x, out_y, out_scale}, 32'd0);
      check("rst_det_count", {28'd0, det_count}, 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_rd_en_before_start", {31'd0, rq_rd_en}, 32'd0);
    end
    check("queue_untouched", pop_cnt, 32'd0);
    push_cnt = pop_cnt;

    // Single detection
    n_exp = 1; e_x[0] = 5; e_y[0] = 7; e_s[0] = 2;
    run_frame(0, -1);

    // Backpressure on first beat
    gen_random(3);
    run_frame(2, -1);

    // Empty stall after start
    gen_random(2);
    force_empty = 1'b1;
    load_frame();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_busy", {31'd0, busy}, 32'd1);
      check("stall_no_rd_en", {31'd0, rq_rd_en}, 32'd0);
    end
    force_empty = 1'b0;
    #1;
    check("rd_en_on_not_empty", {31'd0, rq_rd_en}, 32'd1);
    drain(0, -1);

    // Saturation
    gen_random(20);
    run_frame(0, -1);

    // Random frames, including an empty frame and a near-all-ones record
    for (int k = 0; k < 5; k++) begin
      gen_random((k == 1) ? 0 : int'($urandom_range(1, 7)));
      if (k == 0) begin
        e_x[0] = 4095; e_y[0] = 4095; e_s[0] = 254;
      end
      run_frame(1, -1);
    end

    // Reset mid-frame
    gen_random(3);
    load_frame();
    pulse_start();
    out_ready = 1'b1;
    wait_for(1'b0, "first_accept_timeout");
    out_ready = 1'b0;
    wait_for(1'b1, "second_valid_timeout");
    check("count_before_reset", {28'd0, det_count}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_det_count", {28'd0, det_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    push_cnt = pop_cnt;

    // Start while busy is ignored
    gen_random(5);
    run_frame(0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
